ram_burst_reader: RTL

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader_if.sv | 28 ++
 rtl/ram_burst_reader.sv | 104 ++++++++++
 2 files changed

// File: rtl/ram_burst_reader_if.sv
// Request, RAM and output-stream signals of the burst reader in one bundle.
// The master side is the requester/RAM/sink; the slave side is the reader itself.
interface ram_burst_reader_if #(
    parameter int addr_width = 2,
    parameter int data_width = 3
);
    logic                  start;
    logic [addr_width-1:0] start_addr;
    logic [addr_width:0]   burst_len;
    logic [addr_width-1:0] ram_addr;
    logic [data_width-1:0] ram_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [data_width-1:0] m_data;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    modport master (
        output start, start_addr, burst_len, ram_dout, m_ready,
        input  ram_addr, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        input  start, start_addr, burst_len, ram_dout, m_ready,
        output ram_addr, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/ram_burst_reader.sv
// Reads a burst of consecutive words from a combinational-read RAM onto a valid/ready stream.
// Define RAM_BURST_READER_WRAP_EN to wrap the address past the top of memory instead of truncating there.
//
// state | meaning
// IDLE  | waiting for start; ram_addr holds its last value
// FETCH | register ram_dout for the current address into m_data
// SEND  | m_valid held until the sink accepts the word
// DONE  | one-cycle done pulse, then back to IDLE
module ram_burst_reader #(
    parameter int addr_width = 2,
    parameter int data_width = 3
) (
    input logic            clk,
    input logic            rst,
    ram_burst_reader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [addr_width-1:0] ram_addr_q;
    logic [addr_width:0]   count_q;
    logic [data_width-1:0] m_data_q;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  final_word;

`ifdef RAM_BURST_READER_WRAP_EN
    assign final_word = (count_q == (addr_width+1)'(1));
`else
    // The top address always ends the burst, whatever words remain.
    assign final_word = (count_q == (addr_width+1)'(1)) ||
                        (ram_addr_q == {addr_width{1'b1}});
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ram_addr_q <= '0;
            count_q    <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.burst_len != '0) begin
                            ram_addr_q <= bus.start_addr;
                            count_q    <= bus.burst_len;
                            state      <= FETCH;
                        end else begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                FETCH: begin
                    m_data_q  <= bus.ram_dout;
                    m_valid_q <= 1'b1;
                    m_last_q  <= final_word;
                    state     <= SEND;
                end
                SEND: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        if (m_last_q) begin
                            m_last_q <= 1'b0;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            // Natural overflow gives the wrap; without wrap the top address is always final.
                            ram_addr_q <= ram_addr_q + 1'b1;
                            count_q    <= count_q - 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ram_addr = ram_addr_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_last   = m_last_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
